// File: rtl/pio_pkg.sv
// Shared constants for the PIO bank: register offsets and edge-capture modes.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTSET  = 3'd1;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd2;
    localparam logic [2:0] ADDR_IRQMASK = 3'd3;
    localparam logic [2:0] ADDR_EDGECAP = 3'd4;
    localparam logic [2:0] ADDR_OUTRB   = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pcihellocore_pio_bank_if.sv
// Avalon-MM slave bus of the PIO bank (word addressed, no waitrequest).
interface pcihellocore_pio_bank_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_edge_sync.sv
// Two-flop synchroniser, history flop, warm-up counter and edge detector.
module pio_edge_sync
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EDGE_TYPE  = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_in,
    output logic [DATA_WIDTH-1:0] edge_pulse
);

    logic [DATA_WIDTH-1:0] s1_r;
    logic [DATA_WIDTH-1:0] s2_r;
    logic [DATA_WIDTH-1:0] prev_r;
    logic [1:0]            warm_r;
    logic [DATA_WIDTH-1:0] detect_s;

    // Synchroniser chain and warm-up counter that saturates at 3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r   <= {DATA_WIDTH{1'b0}};
            s2_r   <= {DATA_WIDTH{1'b0}};
            prev_r <= {DATA_WIDTH{1'b0}};
            warm_r <= 2'd0;
        end else begin
            s1_r   <= in_port;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            if (warm_r != 2'd3) begin
                warm_r <= warm_r + 2'd1;
            end else begin
                warm_r <= warm_r;
            end
        end
    end

    // Edge detect; masked off until the history flop holds real input data.
    always_comb begin
        detect_s = {DATA_WIDTH{1'b0}};
        case (EDGE_TYPE)
            EDGE_RISING:  detect_s = s2_r & ~prev_r;
            EDGE_FALLING: detect_s = ~s2_r & prev_r;
            default:      detect_s = s2_r ^ prev_r;
        endcase
        if (warm_r == 2'd3) begin
            edge_pulse = detect_s;
        end else begin
            edge_pulse = {DATA_WIDTH{1'b0}};
        end
    end

    assign sync_in = s2_r;

endmodule

// File: rtl/pcihellocore_pio_bank.sv
// PIO bank: output register with set/clear aliases, synchronised input with
// sticky edge capture, interrupt mask and level interrupt.
module pcihellocore_pio_bank
    import pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          EDGE_TYPE   = EDGE_RISING
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pcihellocore_pio_bank_if.slave  bus,
    input  logic [DATA_WIDTH-1:0]   in_port,
    output logic [DATA_WIDTH-1:0]   out_port,
    output logic                    irq
);

    logic [DATA_WIDTH-1:0] out_r, mask_r, cap_r;
    logic [DATA_WIDTH-1:0] out_nxt_s, mask_nxt_s, cap_nxt_s, clr_s;
    logic [DATA_WIDTH-1:0] sync_in_s, edge_pulse_s, wd_s, rd_s;
    logic                  wr_en_s;
    logic                  unused_wd_s;

    pio_edge_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_edge_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_in    (sync_in_s),
        .edge_pulse (edge_pulse_s)
    );

    assign wr_en_s     = bus.chipselect & ~bus.write_n;
    assign wd_s        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd_s = ^bus.writedata;

    // Register-file next state; an edge detect beats a same-cycle W1C clear.
    always_comb begin
        out_nxt_s  = out_r;
        mask_nxt_s = mask_r;
        clr_s      = {DATA_WIDTH{1'b0}};
        if (wr_en_s) begin
            case (bus.address)
                ADDR_DATA:    out_nxt_s  = wd_s;
                ADDR_OUTSET:  out_nxt_s  = out_r | wd_s;
                ADDR_OUTCLR:  out_nxt_s  = out_r & ~wd_s;
                ADDR_IRQMASK: mask_nxt_s = wd_s;
                ADDR_EDGECAP: clr_s      = wd_s;
                default:      clr_s      = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            clr_s = {DATA_WIDTH{1'b0}};
        end
        cap_nxt_s = (cap_r & ~clr_s) | edge_pulse_s;
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r  <= RESET_VALUE[DATA_WIDTH-1:0];
            mask_r <= {DATA_WIDTH{1'b0}};
            cap_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            out_r  <= out_nxt_s;
            mask_r <= mask_nxt_s;
            cap_r  <= cap_nxt_s;
        end
    end

    // Zero-latency read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_s = {DATA_WIDTH{1'b0}};
        case (bus.address)
            ADDR_DATA:    rd_s = sync_in_s;
            ADDR_IRQMASK: rd_s = mask_r;
            ADDR_EDGECAP: rd_s = cap_r;
            ADDR_OUTRB:   rd_s = out_r;
            default:      rd_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign bus.readdata = 32'(rd_s);
    assign out_port     = out_r;
    assign irq          = |(cap_r & mask_r);

endmodule
